mmv_input_packer: RTL

- Upstream feeder for the MMV input sliding-window unit.
- Accepts the IFM stream one SIMD-wide beat per transfer, channel-fastest within pixel, then pixel-row-major within frame.
- Packs MMV consecutive beats into one MMV*SIMD*IP_PRECISION word, matching the SWU write-port width.
- Handles frames whose beat count is not a multiple of MMV by zero-filling and flushing the last word; supports back-to-back frames at one input beat per cycle.

---
 rtl/mmv_pkg.sv | 18 +
 rtl/mmv_lane_collector.sv | 52 +++++
 rtl/mmv_input_packer.sv | 95 +++++++++
 3 files changed

// File: rtl/mmv_pkg.sv
// Helper functions shared by the MMV input path: the packer here and the sliding-window unit.
package mmv_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int frame_beats(input int h, input int w, input int c, input int simd);
    return h * w * (c / simd);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mmv_lane_collector.sv
// Holds the partial lanes of the word being assembled and builds the zero-filled packed word
// from the stored lanes plus the beat currently on the input.
module mmv_lane_collector
  import mmv_pkg::*;
#(
  parameter int SIMD         = 1,
  parameter int IP_PRECISION = 8,
  parameter int MMV          = 2,
  localparam int LW          = SIMD * IP_PRECISION,
  localparam int LIW         = clog2_min1(MMV)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_fire,
  input  logic              complete,
  input  logic [LW-1:0]     in_data,
  output logic [LIW-1:0]    lane_idx,
  output logic [MMV*LW-1:0] packed_word
);

  localparam int LANE_REGS = (MMV > 1) ? MMV - 1 : 1;

  logic [LW-1:0] lane_reg [LANE_REGS];

  // The completing beat bypasses the lane registers, so only lanes 0..MMV-2 are ever stored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lane_idx <= '0;
      for (int i = 0; i < LANE_REGS; i++) lane_reg[i] <= '0;
    end else if (in_fire) begin
      if (complete) begin
        lane_idx <= '0;
      end else begin
        for (int i = 0; i < MMV - 1; i++) begin
          if (lane_idx == LIW'(i)) lane_reg[i] <= in_data;
        end
        lane_idx <= (MMV == 1) ? '0 : lane_idx + LIW'(1);
      end
    end
  end

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < MMV - 1; i++) begin
      if (LIW'(i) < lane_idx) packed_word[i*LW +: LW] = lane_reg[i];
    end
    for (int i = 0; i < MMV; i++) begin
      if (LIW'(i) == lane_idx) packed_word[i*LW +: LW] = in_data;
    end
  end

endmodule

// File: rtl/mmv_input_packer.sv
// Packs MMV consecutive SIMD-wide IFM beats into one SWU write word, flushing a zero-filled
// word at the end of each frame and pulsing frame_done when the frame's last word is taken.
module mmv_input_packer
  import mmv_pkg::*;
#(
  parameter int SIMD         = 1,
  parameter int IP_PRECISION = 8,
  parameter int MMV          = 2,
  parameter int IFMChannels  = 2,
  parameter int IFMWidth     = 8,
  parameter int IFMHeight    = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [SIMD*IP_PRECISION-1:0]     ip_axis_tdata,
  input  logic                             ip_axis_tvalid,
  output logic                             ip_axis_tready,
  output logic [MMV*SIMD*IP_PRECISION-1:0] op_axis_tdata,
  output logic                             op_axis_tvalid,
  input  logic                             op_axis_tready,
  output logic                             frame_done
);

  localparam int LW          = SIMD * IP_PRECISION;
  localparam int FRAME_BEATS = frame_beats(IFMHeight, IFMWidth, IFMChannels, SIMD);
  localparam int FRAME_WORDS = ceil_div(FRAME_BEATS, MMV);
  localparam int BW          = clog2_min1(FRAME_BEATS);
  localparam int WW          = clog2_min1(FRAME_WORDS);
  localparam int LIW         = clog2_min1(MMV);

  logic [LIW-1:0]    lane_idx;
  logic [MMV*LW-1:0] packed_word;
  logic [BW-1:0]     beat_cnt;
  logic [WW-1:0]     word_cnt;
  logic              last_beat;
  logic              completing_lane;
  logic              out_free;
  logic              in_fire;
  logic              complete;
  logic              out_fire;

  // Partial lanes are always accepted; only a completing beat has to wait for the output slot.
  always_comb begin
    last_beat       = (beat_cnt == BW'(FRAME_BEATS - 1));
    completing_lane = (lane_idx == LIW'(MMV - 1)) || last_beat;
    out_free        = !op_axis_tvalid || op_axis_tready;
    ip_axis_tready  = out_free || !completing_lane;
    in_fire         = ip_axis_tvalid && ip_axis_tready;
    complete        = in_fire && completing_lane;
    out_fire        = op_axis_tvalid && op_axis_tready;
  end

  mmv_lane_collector #(
    .SIMD         (SIMD),
    .IP_PRECISION (IP_PRECISION),
    .MMV          (MMV)
  ) u_collector (
    .clk         (clk),
    .resetn      (resetn),
    .in_fire     (in_fire),
    .complete    (complete),
    .in_data     (ip_axis_tdata),
    .lane_idx    (lane_idx),
    .packed_word (packed_word)
  );

  // A new word may replace the one being drained in the same cycle, keeping full throughput.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt       <= '0;
      word_cnt       <= '0;
      op_axis_tdata  <= '0;
      op_axis_tvalid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_fire) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
      if (complete) begin
        op_axis_tdata  <= packed_word;
        op_axis_tvalid <= 1'b1;
      end else if (out_fire) begin
        op_axis_tvalid <= 1'b0;
      end
      if (out_fire) begin
        if (word_cnt == WW'(FRAME_WORDS - 1)) begin
          word_cnt   <= '0;
          frame_done <= 1'b1;
        end else begin
          word_cnt <= word_cnt + WW'(1);
        end
      end
    end
  end

endmodule
